// File: rtl/demux1_7_reg.sv
// Registered 1-to-7 demultiplexer: steers a write into one of seven holding
// registers and reports strobes, sticky written flags, a write count and errors.
module demux1_7_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       selector,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic [WIDTH-1:0] data_4,
  output logic [WIDTH-1:0] data_5,
  output logic [WIDTH-1:0] data_6,
  output logic [6:0]       wr_strobe,
  output logic [6:0]       written,
  output logic [7:0]       wr_count,
  output logic             err_sel
);

  logic [WIDTH-1:0] regs [7];
  logic             accept;
  logic             illegal;
  logic [6:0]       dest_onehot;
  logic [6:0]       written_base;
  logic [7:0]       count_base;

  assign accept  = wr_en && (selector != 3'd7);
  assign illegal = wr_en && (selector == 3'd7);

  // Clear is applied before a same-cycle write, so the write builds on zeroed flags.
  always_comb begin
    dest_onehot  = 7'd0;
    written_base = written;
    count_base   = wr_count;
    if (accept) begin
      dest_onehot = 7'd1 << selector;
    end
    if (clr_flags) begin
      written_base = 7'd0;
      count_base   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        regs[i] <= '0;
      end
      wr_strobe <= 7'd0;
      written   <= 7'd0;
      wr_count  <= 8'd0;
      err_sel   <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (accept && (selector == 3'(i))) begin
          regs[i] <= data_in;
        end
      end
      wr_strobe <= dest_onehot;
      err_sel   <= illegal;
      written   <= written_base | dest_onehot;
      if (accept && (count_base != 8'hFF)) begin
        wr_count <= count_base + 8'd1;
      end else begin
        wr_count <= count_base;
      end
    end
  end

  assign data_0 = regs[0];
  assign data_1 = regs[1];
  assign data_2 = regs[2];
  assign data_3 = regs[3];
  assign data_4 = regs[4];
  assign data_5 = regs[5];
  assign data_6 = regs[6];

endmodule

// File: tb/tb_demux1_7_reg.sv
// Self-checking bench for demux1_7_reg: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_demux1_7_reg;

  logic        clk;
  logic        reset;
  logic [2:0]  selector;
  logic [31:0] data_in;
  logic        wr_en;
  logic        clr_flags;
  logic [31:0] data_0, data_1, data_2, data_3, data_4, data_5, data_6;
  logic [6:0]  wr_strobe;
  logic [6:0]  written;
  logic [7:0]  wr_count;
  logic        err_sel;

  logic [31:0] dut_data [7];

  int n_compared;
  int n_mismatched;

  // Reference model state
  logic [31:0] m_data [7];
  bit          m_written [7];
  int          m_count;
  int          m_strobe_idx;
  bit          m_err;

  demux1_7_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .selector  (selector),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .clr_flags (clr_flags),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .data_4    (data_4),
    .data_5    (data_5),
    .data_6    (data_6),
    .wr_strobe (wr_strobe),
    .written   (written),
    .wr_count  (wr_count),
    .err_sel   (err_sel)
  );

  assign dut_data[0] = data_0;
  assign dut_data[1] = data_1;
  assign dut_data[2] = data_2;
  assign dut_data[3] = data_3;
  assign dut_data[4] = data_4;
  assign dut_data[5] = data_5;
  assign dut_data[6] = data_6;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_written();
    logic [6:0] v;
    v = 7'd0;
    for (int i = 0; i < 7; i++) v[i] = m_written[i];
    return v;
  endfunction

  function automatic logic [6:0] exp_strobe();
    logic [6:0] v;
    v = 7'd0;
    if (m_strobe_idx >= 0) v[m_strobe_idx] = 1'b1;
    return v;
  endfunction

  // Drives one request, waits for the sampling edge, advances the model, then
  // waits 1 time unit so callers sample outputs away from the edge.
  task automatic step(input bit rst, input bit wr, input bit clr,
                      input logic [2:0] sel, input logic [31:0] din);
    reset = rst; wr_en = wr; clr_flags = clr; selector = sel; data_in = din;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 7; i++) begin
        m_data[i] = 32'd0;
        m_written[i] = 1'b0;
      end
      m_count = 0; m_strobe_idx = -1; m_err = 1'b0;
    end else begin
      m_strobe_idx = -1;
      m_err = 1'b0;
      if (clr) begin
        for (int i = 0; i < 7; i++) m_written[i] = 1'b0;
        m_count = 0;
      end
      if (wr && int'(sel) <= 6) begin
        m_data[sel] = din;
        m_written[sel] = 1'b1;
        m_strobe_idx = int'(sel);
        if (m_count < 255) m_count = m_count + 1;
      end else if (wr) begin
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 3'd1, 32'hFFFF_FFFF);
    step(1, 0, 0, 3'd0, 32'd0);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 3'($urandom_range(0, 7)), $urandom);
      for (int i = 0; i < 7; i++) begin
        n_compared++;
        if (dut_data[i] !== 32'd0) begin
          n_mismatched++;
          $display("[TB] FAIL reset_data%0d: got %h expected 0", i, dut_data[i]);
        end
      end
      n_compared++;
      if ({wr_strobe, written, wr_count, err_sel} !== 23'd0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_flags: got strobe=%b written=%b count=%0d err=%b expected all 0",
                 wr_strobe, written, wr_count, err_sel);
      end
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 7; s++) begin
      step(0, 1, 0, 3'(s), 32'hA000_0000 + 32'(s));
      n_compared++;
      if (wr_strobe !== 7'(1 << s)) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_strobe%0d: got %b expected %b", s, wr_strobe, 7'(1 << s));
      end
      n_compared++;
      if (dut_data[s] !== 32'hA000_0000 + 32'(s)) begin
        n_mismatched++;
        $display("[TB] FAIL sweep_data%0d: got %h expected %h", s, dut_data[s], 32'hA000_0000 + 32'(s));
      end
    end
    n_compared++;
    if (written !== 7'h7F) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_written: got %b expected 1111111", written);
    end
    n_compared++;
    if (wr_count !== 8'd7) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_count: got %0d expected 7", wr_count);
    end
  endtask

  task automatic test_illegal();
    step(0, 1, 0, 3'd7, 32'hDEAD_BEEF);
    n_compared++;
    if (err_sel !== 1'b1 || wr_strobe !== 7'd0) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_pulse: got err=%b strobe=%b expected err=1 strobe=0", err_sel, wr_strobe);
    end
    n_compared++;
    if (written !== 7'h7F || wr_count !== 8'd7) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_flags: got written=%b count=%0d expected 1111111/7", written, wr_count);
    end
    for (int i = 0; i < 7; i++) begin
      n_compared++;
      if (dut_data[i] !== 32'hA000_0000 + 32'(i)) begin
        n_mismatched++;
        $display("[TB] FAIL illegal_data%0d: got %h expected %h", i, dut_data[i], 32'hA000_0000 + 32'(i));
      end
    end
    step(0, 0, 0, 3'd7, 32'hDEAD_BEEF);
    n_compared++;
    if (err_sel !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_one_cycle: got err=%b expected 0", err_sel);
    end
  endtask

  task automatic test_clear_write();
    step(0, 1, 1, 3'd3, 32'h0000_1234);
    n_compared++;
    if (written !== 7'b0001000 || wr_count !== 8'd1) begin
      n_mismatched++;
      $display("[TB] FAIL clear_write_flags: got written=%b count=%0d expected 0001000/1", written, wr_count);
    end
    n_compared++;
    if (data_3 !== 32'h0000_1234 || data_0 !== 32'hA000_0000) begin
      n_mismatched++;
      $display("[TB] FAIL clear_write_data: got d3=%h d0=%h expected 00001234/a0000000", data_3, data_0);
    end
    n_compared++;
    if (wr_strobe !== 7'b0001000) begin
      n_mismatched++;
      $display("[TB] FAIL clear_write_strobe: got %b expected 0001000", wr_strobe);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] last;
    int strobe_bad;
    strobe_bad = 0;
    last = 32'd0;
    for (int k = 1; k <= 300; k++) begin
      last = $urandom;
      step(0, 1, 0, 3'd5, last);
      if (wr_strobe !== 7'b0100000) strobe_bad++;
      n_compared++;
      if (int'(wr_count) !== ((1 + k > 255) ? 255 : 1 + k)) begin
        n_mismatched++;
        $display("[TB] FAIL sat_count_%0d: got %0d expected %0d", k, wr_count, (1 + k > 255) ? 255 : 1 + k);
      end
    end
    n_compared++;
    if (strobe_bad != 0) begin
      n_mismatched++;
      $display("[TB] FAIL sat_strobe: got %0d bad strobe cycles expected 0", strobe_bad);
    end
    n_compared++;
    if (data_5 !== last || wr_count !== 8'd255) begin
      n_mismatched++;
      $display("[TB] FAIL sat_final: got d5=%h count=%0d expected %h/255", data_5, wr_count, last);
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 1, 0, 3'd2, 32'h55);
    n_compared++;
    if (data_2 !== 32'h55 || wr_strobe !== 7'b0000100) begin
      n_mismatched++;
      $display("[TB] FAIL midstream_write: got d2=%h strobe=%b expected 55/0000100", data_2, wr_strobe);
    end
    step(1, 1, 0, 3'd4, 32'h66);
    for (int i = 0; i < 7; i++) begin
      n_compared++;
      if (dut_data[i] !== 32'd0) begin
        n_mismatched++;
        $display("[TB] FAIL midstream_data%0d: got %h expected 0", i, dut_data[i]);
      end
    end
    n_compared++;
    if ({wr_strobe, written, wr_count, err_sel} !== 23'd0) begin
      n_mismatched++;
      $display("[TB] FAIL midstream_flags: got strobe=%b written=%b count=%0d err=%b expected all 0",
               wr_strobe, written, wr_count, err_sel);
    end
  endtask

  task automatic test_random();
    bit rst, wr, clr;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 7) == 0);
      wr  = ($urandom_range(0, 3) != 0);
      step(rst, wr, clr, 3'($urandom_range(0, 7)), $urandom);
      for (int i = 0; i < 7; i++) begin
        n_compared++;
        if (dut_data[i] !== m_data[i]) begin
          n_mismatched++;
          $display("[TB] FAIL rand_data%0d_c%0d: got %h expected %h", i, c, dut_data[i], m_data[i]);
        end
      end
      n_compared++;
      if (wr_strobe !== exp_strobe() || err_sel !== m_err) begin
        n_mismatched++;
        $display("[TB] FAIL rand_pulses_c%0d: got strobe=%b err=%b expected %b/%b",
                 c, wr_strobe, err_sel, exp_strobe(), m_err);
      end
      n_compared++;
      if (written !== exp_written() || int'(wr_count) !== m_count) begin
        n_mismatched++;
        $display("[TB] FAIL rand_flags_c%0d: got written=%b count=%0d expected %b/%0d",
                 c, written, wr_count, exp_written(), m_count);
      end
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    reset = 1'b1; wr_en = 1'b0; clr_flags = 1'b0; selector = 3'd0; data_in = 32'd0;
    for (int i = 0; i < 7; i++) begin
      m_data[i] = 32'd0;
      m_written[i] = 1'b0;
    end
    m_count = 0; m_strobe_idx = -1; m_err = 1'b0;
    #2;
    test_reset();
    test_sweep();
    test_illegal();
    test_clear_write();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
